fp_mul_seq: RTL

Parametrised, multi-cycle IEEE-754 binary floating-point multiplier with a valid/ready handshake on both sides. It computes the mantissa product with an iterative shift-add datapath, then normalises and rounds in one cycle using guard and sticky bits. It supports four rounding modes and any exponent/fraction width, and reports IEEE exception flags. It is the sequential, width-generic successor to the combinational single-precision multiplier in the FPU, and sits behind the FPU operand registers.

---
 rtl/fp_mul_seq.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier (shift-add significand, one-cycle normalise/round), width-generic.
// Latency MAN_W+3 cycles (1 for special operands); result held in DONE until ready_out, no input accepted while busy.
module fp_mul_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_in,
   output logic                       ready_in,
   input  logic [1+EXP_W+MAN_W-1:0]   A,
   input  logic [1+EXP_W+MAN_W-1:0]   B,
   input  logic [1:0]                 round_mode,
   output logic                       valid_out,
   input  logic                       ready_out,
   output logic [1+EXP_W+MAN_W-1:0]   result,
   output logic                       error,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       inexact
);

   localparam int W      = 1 + EXP_W + MAN_W;
   localparam int SIG_W  = MAN_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int XW     = EXP_W + 2;
   localparam int CNT_W  = $clog2(SIG_W + 1);

   localparam logic signed [XW-1:0] BIAS     = XW'(2 ** (EXP_W - 1) - 1);
   localparam logic signed [XW-1:0] EXP_MAX  = XW'(2 ** EXP_W - 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SIG_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_RND,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic                    sign_q;
   logic [1:0]              mode_q;
   logic signed [XW-1:0]    exp_q;
   logic [SIG_W-1:0]        mcand_q;
   logic [SIG_W-1:0]        mplier_q;
   logic [PROD_W-1:0]       acc_q;
   logic [CNT_W-1:0]        cnt_q;

   // Operand field decode
   logic             a_sign, b_sign;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_frac, b_frac;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic             spec_nan, spec_inf, spec_zero, special;
   logic [W-1:0]     spec_res;

   assign a_sign = A[W-1];
   assign b_sign = B[W-1];
   assign a_exp  = A[W-2:MAN_W];
   assign b_exp  = B[W-2:MAN_W];
   assign a_frac = A[MAN_W-1:0];
   assign b_frac = B[MAN_W-1:0];

   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign a_inf  = (&a_exp) && (a_frac == '0);
   assign b_inf  = (&b_exp) && (b_frac == '0);
   assign a_nan  = (&a_exp) && (|a_frac);
   assign b_nan  = (&b_exp) && (|b_frac);

   assign spec_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
   assign spec_inf  = a_inf || b_inf;
   assign spec_zero = a_zero || b_zero;
   assign special   = spec_nan || spec_inf || spec_zero;

   always_comb begin
      spec_res = '0;
      if (spec_nan)
         spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if (spec_inf)
         spec_res = {a_sign ^ b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
         spec_res = {a_sign ^ b_sign, {(W-1){1'b0}}};
   end

   // One shift-add step: add into the upper half, then shift the accumulator right
   logic [SIG_W:0]    add_sum;
   logic [PROD_W-1:0] acc_nxt;

   assign add_sum = {1'b0, acc_q[PROD_W-1:SIG_W]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_nxt = {add_sum, acc_q[SIG_W-1:1]};

   // Normalise, round, range check
   logic [PROD_W-1:0]    norm;
   logic [SIG_W-1:0]     sig;
   logic                 g_bit, s_bit, round_up, carry;
   logic [SIG_W:0]       sig_rnd;
   logic [MAN_W-1:0]     frac_f;
   logic signed [XW-1:0] exp_n, exp_f;
   logic                 ovf, unf, inf_ok;
   logic [W-1:0]         rnd_res;

   assign norm    = acc_q[PROD_W-1] ? acc_q : {acc_q[PROD_W-2:0], 1'b0};
   assign sig     = norm[PROD_W-1:SIG_W];
   assign g_bit   = norm[SIG_W-1];
   assign s_bit   = |norm[SIG_W-2:0];
   assign exp_n   = exp_q + $signed({{(XW-1){1'b0}}, acc_q[PROD_W-1]});

   always_comb begin
      round_up = 1'b0;
      case (mode_q)
         2'b00:   round_up = (g_bit || s_bit) && !sign_q;
         2'b01:   round_up = (g_bit || s_bit) && sign_q;
         2'b10:   round_up = g_bit && (s_bit || sig[0]);
         default: round_up = g_bit;
      endcase
   end

   assign sig_rnd = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
   assign carry   = sig_rnd[SIG_W];
   assign frac_f  = carry ? sig_rnd[MAN_W:1] : sig_rnd[MAN_W-1:0];
   assign exp_f   = exp_n + $signed({{(XW-1){1'b0}}, carry});
   assign ovf     = (exp_f >= EXP_MAX);
   assign unf     = (exp_f <= EXP_ZERO);
   // Directed modes saturate to max-finite when rounding away from the overflow direction
   assign inf_ok  = mode_q[1] || (mode_q == 2'b00 && !sign_q) || (mode_q == 2'b01 && sign_q);

   always_comb begin
      rnd_res = '0;
      if (ovf) begin
         if (inf_ok)
            rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         else
            rnd_res = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end else if (unf) begin
         rnd_res = {sign_q, {(W-1){1'b0}}};
      end else begin
         rnd_res = {sign_q, exp_f[EXP_W-1:0], frac_f};
      end
   end

   // Control FSM
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_in  = 1'b0;
      valid_out = 1'b0;
      case (state)
         S_IDLE: begin
            ready_in = 1'b1;
            if (valid_in)
               state_nxt = special ? S_DONE : S_MUL;
         end
         S_MUL: begin
            if (cnt_q == CNT_LAST)
               state_nxt = S_RND;
         end
         S_RND: begin
            state_nxt = S_DONE;
         end
         S_DONE: begin
            valid_out = 1'b1;
            if (ready_out)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         sign_q    <= 1'b0;
         mode_q    <= 2'b00;
         exp_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result    <= '0;
         error     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (valid_in) begin
                  sign_q   <= a_sign ^ b_sign;
                  mode_q   <= round_mode;
                  exp_q    <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
                  mcand_q  <= {1'b1, a_frac};
                  mplier_q <= {1'b1, b_frac};
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  if (special) begin
                     result    <= spec_res;
                     error     <= spec_nan;
                     overflow  <= 1'b0;
                     underflow <= 1'b0;
                     inexact   <= 1'b0;
                  end
               end
            end
            S_MUL: begin
               acc_q    <= acc_nxt;
               mplier_q <= {1'b0, mplier_q[SIG_W-1:1]};
               cnt_q    <= cnt_q + 1'b1;
            end
            S_RND: begin
               result    <= rnd_res;
               error     <= 1'b0;
               overflow  <= ovf;
               underflow <= unf && !ovf;
               inexact   <= g_bit || s_bit || ovf || unf;
            end
            default: ;
         endcase
      end
   end

endmodule
